// File: rtl/instr_word_loader.sv
// Packs received UART bytes into instruction words and writes them sequentially to instruction memory.
// Detects the halt word, flags memory full and late-byte overflow, and supports both byte orders.
module instr_word_loader #(
    parameter int                 NB_BYTE   = 8,
    parameter int                 NB_WORD   = 32,
    parameter int                 NB_ADDR   = 7,
    parameter bit                 MSB_FIRST = 1'b1,
    parameter logic [NB_WORD-1:0] HALT_WORD = {NB_WORD{1'b1}}
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start_i,
    input  logic               rx_done_i,
    input  logic [NB_BYTE-1:0] rx_data_i,
    output logic               wr_en_o,
    output logic [NB_ADDR-1:0] wr_addr_o,
    output logic [NB_WORD-1:0] wr_data_o,
    output logic               loading_o,
    output logic               done_o,
    output logic               full_o,
    output logic               overflow_o,
    output logic [NB_ADDR:0]   word_count_o
);

    localparam int                 NPW       = NB_WORD / NB_BYTE;
    localparam int                 IDX_W     = (NPW > 1) ? $clog2(NPW) : 1;
    localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(NPW - 1);
    localparam logic [NB_ADDR-1:0] ADDR_MAX  = {NB_ADDR{1'b1}};
    localparam logic [NB_WORD-1:0] BYTE_MASK = NB_WORD'({NB_BYTE{1'b1}});

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NB_WORD-1:0] word_q, word_d;
    logic [NB_ADDR-1:0] addr_q, addr_d;
    logic [NB_ADDR:0]   count_q, count_d;
    logic               full_q, full_d;
    logic               ovf_q, ovf_d;
    logic               wr_en_q, wr_en_d;
    logic [NB_ADDR-1:0] wr_addr_q, wr_addr_d;
    logic [NB_WORD-1:0] wr_data_q, wr_data_d;
    logic               last_write;
    int unsigned        byte_sh;

    // The word just presented on the write port ends the load; the FSM leaves LOAD one cycle later.
    assign last_write = wr_en_q && ((wr_data_q == HALT_WORD) || (wr_addr_q == ADDR_MAX));

    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        state_d   = state_q;
        idx_d     = idx_q;
        word_d    = word_q;
        addr_d    = addr_q;
        count_d   = count_q;
        full_d    = full_q;
        ovf_d     = ovf_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        byte_sh   = MSB_FIRST ? (NPW - 1 - int'(idx_q)) * NB_BYTE : int'(idx_q) * NB_BYTE;

        if (start_i) begin
            state_d = ST_LOAD;
            idx_d   = '0;
            addr_d  = '0;
            count_d = '0;
            full_d  = 1'b0;
            ovf_d   = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: ;
                ST_LOAD: begin
                    if (last_write) begin
                        state_d = ST_DONE;
                        full_d  = (wr_data_q != HALT_WORD);
                        if (rx_done_i) ovf_d = 1'b1;
                    end else if (rx_done_i) begin
                        word_d = (word_q & ~(BYTE_MASK << byte_sh)) | (NB_WORD'(rx_data_i) << byte_sh);
                        if (idx_q == IDX_LAST) begin
                            idx_d     = '0;
                            wr_en_d   = 1'b1;
                            wr_data_d = word_d;
                            wr_addr_d = addr_q;
                            count_d   = count_q + 1'b1;
                            // Saturate at the top so the load never wraps back onto address 0.
                            if (addr_q != ADDR_MAX) addr_d = addr_q + 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (rx_done_i) ovf_d = 1'b1;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            word_q    <= '0;
            addr_q    <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            ovf_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge value of the others.
            state_q   <= state_d;
            idx_q     <= idx_d;
            word_q    <= word_d;
            addr_q    <= addr_d;
            count_q   <= count_d;
            full_q    <= full_d;
            ovf_q     <= ovf_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign wr_en_o      = wr_en_q;
    assign wr_addr_o    = wr_addr_q;
    assign wr_data_o    = wr_data_q;
    assign loading_o    = (state_q == ST_LOAD);
    assign done_o       = (state_q == ST_DONE);
    assign full_o       = full_q;
    assign overflow_o   = ovf_q;
    assign word_count_o = count_q;

endmodule
